dfh_scratch_walker: RTL and testbench

//  Hardware successor to the static feature/scratch table used by the PF/VF access tests.

---
 rtl/dfh_scratch_walker.sv | 198 +++++++++++++++++++
 tb/tb_dfh_scratch_walker.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dfh_scratch_walker.sv
// dfh_scratch_walker: walks a DFH list, matches GUIDs to a table and self-tests matched scratch registers (DFH_WALK_RESTORE_EN restores original values)
module dfh_scratch_walker #(
  parameter int          ADDR_W      = 20,
  parameter int          NUM_FEAT    = 8,
  parameter int          MAX_HOPS    = 64,
  parameter int          TIMEOUT     = 1024,
  parameter logic [63:0] SCRATCH_PAT = 64'h5A5A_0000_A5A5_0000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [ADDR_W-1:0]        base_addr,
  input  logic [NUM_FEAT*128-1:0]  tbl_guid,
  input  logic [NUM_FEAT*16-1:0]   tbl_scratch,
  output logic                     req_valid,
  input  logic                     req_ready,
  output logic                     req_write,
  output logic [ADDR_W-1:0]        req_addr,
  output logic [63:0]              req_wdata,
  input  logic                     rsp_valid,
  input  logic [63:0]              rsp_rdata,
  output logic                     busy,
  output logic                     done,
  output logic [NUM_FEAT-1:0]      found,
  output logic [NUM_FEAT-1:0]      pass,
  output logic                     err_timeout,
  output logic                     err_hops,
  output logic [7:0]               hop_cnt
);
  localparam int IW = NUM_FEAT > 1 ? $clog2(NUM_FEAT) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);
`ifdef DFH_WALK_RESTORE_EN
  typedef enum logic [3:0] {IDLE, RD_DFH, RD_GL, RD_GH, MATCH, RD_ORIG, WR_SCR, RD_SCR, CHK, WR_RESTORE, NEXT, DONE} state_t;
  logic [63:0] orig;
`else
  typedef enum logic [3:0] {IDLE, RD_DFH, RD_GL, RD_GH, MATCH, WR_SCR, RD_SCR, CHK, NEXT, DONE} state_t;
`endif
  state_t state, nxt;
  logic [ADDR_W-1:0] cur, scr_addr, addr_raw;
  logic [23:0] next_off;
  logic eol;
  logic [63:0] guid_l, guid_h, scr_rd;
  logic [NUM_FEAT*128-1:0] snap_guid;
  logic [NUM_FEAT*16-1:0] snap_scr;
  logic [NUM_FEAT-1:0] tested;
  logic [IW-1:0] idx, hit_idx;
  logic [TW-1:0] tcnt;
  logic [7:0] hop_nxt;
  logic hit, wait_rsp, is_rd, is_wr, got_rsp, tmo, stop;

  assign got_rsp   = wait_rsp & rsp_valid;
  assign tmo       = wait_rsp & ~rsp_valid & (tcnt == TW'(TIMEOUT - 1));
  assign hop_nxt   = hop_cnt + 8'd1;
  assign stop      = eol | (next_off == 24'd0) | (hop_nxt == 8'(MAX_HOPS));
  assign scr_addr  = cur + ADDR_W'(snap_scr[16*idx +: 16]);
  assign req_addr  = {addr_raw[ADDR_W-1:3], 3'b000};
  assign req_valid = is_wr | (is_rd & ~wait_rsp);
  assign req_write = is_wr;
  assign busy      = (state != IDLE) && (state != DONE);
  assign done      = state == DONE;

  // lowest table index whose GUID equals the current node's GUID
  always_comb begin
    hit = 1'b0;
    hit_idx = '0;
    for (int i = NUM_FEAT - 1; i >= 0; i--)
      if (snap_guid[128*i +: 128] == {guid_h, guid_l}) begin
        hit = 1'b1;
        hit_idx = IW'(i);
      end
  end

  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= nxt;

  // next state and CSR request generation
  always_comb begin
    nxt = state;
    is_rd = 1'b0;
    is_wr = 1'b0;
    addr_raw = cur;
    req_wdata = SCRATCH_PAT ^ 64'(idx);
    case (state)
      IDLE: nxt = start ? RD_DFH : IDLE;
      RD_DFH: begin
        is_rd = 1'b1;
        nxt = got_rsp ? RD_GL : state;
      end
      RD_GL: begin
        is_rd = 1'b1;
        addr_raw = cur + ADDR_W'(8);
        nxt = got_rsp ? RD_GH : state;
      end
      RD_GH: begin
        is_rd = 1'b1;
        addr_raw = cur + ADDR_W'(16);
        nxt = got_rsp ? MATCH : state;
      end
`ifdef DFH_WALK_RESTORE_EN
      MATCH: nxt = hit ? RD_ORIG : NEXT;
      RD_ORIG: begin
        is_rd = 1'b1;
        addr_raw = scr_addr;
        nxt = got_rsp ? WR_SCR : state;
      end
      CHK: nxt = WR_RESTORE;
      WR_RESTORE: begin
        is_wr = 1'b1;
        addr_raw = scr_addr;
        req_wdata = orig;
        nxt = req_ready ? NEXT : state;
      end
`else
      MATCH: nxt = hit ? WR_SCR : NEXT;
      CHK: nxt = NEXT;
`endif
      WR_SCR: begin
        is_wr = 1'b1;
        addr_raw = scr_addr;
        nxt = req_ready ? RD_SCR : state;
      end
      RD_SCR: begin
        is_rd = 1'b1;
        addr_raw = scr_addr;
        nxt = got_rsp ? CHK : state;
      end
      NEXT: nxt = stop ? DONE : RD_DFH;
      DONE: nxt = IDLE;
      default: nxt = IDLE;
    endcase
    if (tmo) nxt = DONE;
  end

  // walk datapath: response capture, timeout counter, result bits
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cur <= '0;
      next_off <= '0;
      eol <= 1'b0;
      guid_l <= '0;
      guid_h <= '0;
      scr_rd <= '0;
`ifdef DFH_WALK_RESTORE_EN
      orig <= '0;
`endif
      snap_guid <= '0;
      snap_scr <= '0;
      tested <= '0;
      idx <= '0;
      tcnt <= '0;
      wait_rsp <= 1'b0;
      found <= '0;
      pass <= '0;
      err_timeout <= 1'b0;
      err_hops <= 1'b0;
      hop_cnt <= '0;
    end else begin
      if (state == IDLE && start) begin
        cur <= base_addr;
        snap_guid <= tbl_guid;
        snap_scr <= tbl_scratch;
        tested <= '0;
        found <= '0;
        pass <= '0;
        err_timeout <= 1'b0;
        err_hops <= 1'b0;
        hop_cnt <= '0;
      end
      if (req_valid && req_ready && !req_write) begin
        wait_rsp <= 1'b1;
        tcnt <= '0;
      end else if (got_rsp || tmo) wait_rsp <= 1'b0;
      else if (wait_rsp) tcnt <= tcnt + 1'b1;
      if (tmo) err_timeout <= 1'b1;
      if (got_rsp && state == RD_DFH) {eol, next_off} <= rsp_rdata[40:16];
      if (got_rsp && state == RD_GL) guid_l <= rsp_rdata;
      if (got_rsp && state == RD_GH) guid_h <= rsp_rdata;
      if (got_rsp && state == RD_SCR) scr_rd <= rsp_rdata;
`ifdef DFH_WALK_RESTORE_EN
      if (got_rsp && state == RD_ORIG) orig <= rsp_rdata;
`endif
      if (state == MATCH && hit) begin
        idx <= hit_idx;
        found[hit_idx] <= 1'b1;
      end
      if (state == CHK) begin
        pass[idx] <= (tested[idx] ? pass[idx] : 1'b1) & (scr_rd == (SCRATCH_PAT ^ 64'(idx)));
        tested[idx] <= 1'b1;
      end
      if (state == NEXT) begin
        hop_cnt <= hop_nxt;
        cur <= cur + ADDR_W'(next_off);
        if (!eol && next_off != 24'd0 && hop_nxt == 8'(MAX_HOPS)) err_hops <= 1'b1;
      end
    end
endmodule

// File: tb/tb_dfh_scratch_walker.sv
// tb_dfh_scratch_walker: randomized CSR fabric with a list-walking reference model
module tb_dfh_scratch_walker;
  localparam int AW = 20, NF = 8, MAXH = 4, TMO = 1024;
  localparam logic [63:0] PAT = 64'h5A5A_0000_A5A5_0000;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [NF*128-1:0] tbl_guid = '0;
  logic [NF*16-1:0] tbl_scratch = '0;
  logic req_valid, req_write, req_ready = 1'b0, rsp_valid = 1'b0;
  logic [AW-1:0] req_addr;
  logic [63:0] req_wdata, rsp_rdata = '0;
  logic busy, done, err_timeout, err_hops;
  logic [NF-1:0] found, pass;
  logic [7:0] hop_cnt;

  dfh_scratch_walker #(.ADDR_W(AW), .NUM_FEAT(NF), .MAX_HOPS(MAXH), .TIMEOUT(TMO), .SCRATCH_PAT(PAT)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .tbl_guid(tbl_guid), .tbl_scratch(tbl_scratch),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy), .done(done), .found(found), .pass(pass),
    .err_timeout(err_timeout), .err_hops(err_hops), .hop_cnt(hop_cnt));

  always #5 clk = ~clk;

  logic [63:0] mem [int];
  bit stuck [int];
  logic [127:0] tg [NF];
  logic [15:0] ts [NF];
  int n_vec = 0, n_err = 0;
  int stall_left = 0, drop_addr = -1, pa = 0, dly = 0, last_cyc = 0;
  bit pend = 0;
  logic [NF-1:0] e_found, e_pass;
  int e_hops;
  bit e_eh;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] rd(input int a);
    return mem.exists(a) ? mem[a] : 64'd0;
  endfunction

  // CSR fabric: random ready, random response delay, stuck scratch words, spurious rsp_valid
  initial forever begin
    @(negedge clk);
    if (rst) begin
      req_ready = 1'b0;
      rsp_valid = 1'b0;
      pend = 0;
    end else begin
      rsp_valid = 1'b0;
      if (pend) begin
        if (dly == 0) begin
          rsp_valid = 1'b1;
          rsp_rdata = stuck.exists(pa) ? 64'd0 : rd(pa);
          pend = 0;
        end else dly--;
      end else if (drop_addr < 0 && $urandom % 8 == 0) begin
        rsp_valid = 1'b1;
        rsp_rdata = {$urandom, $urandom};
      end
      if (stall_left > 0 && req_valid) begin
        req_ready = 1'b0;
        stall_left--;
      end else req_ready = ($urandom % 4) != 0;
      if (req_valid && req_ready) begin
        if (req_write) begin
          if (!stuck.exists(int'(req_addr))) mem[int'(req_addr)] = req_wdata;
        end else if (int'(req_addr) != drop_addr) begin
          pend = 1;
          pa = int'(req_addr);
          dly = $urandom % 4;
        end
      end
    end
  end

  // reference: follow the list through memory, apply the match/test rules per node
  task automatic model(input int base);
    int cur, m, a;
    logic [63:0] d;
    logic [127:0] g;
    bit [NF-1:0] tested;
    cur = base;
    tested = '0;
    e_found = '0;
    e_pass = '0;
    e_hops = 0;
    e_eh = 0;
    forever begin
      d = rd(cur);
      g = {rd(cur + 16), rd(cur + 8)};
      m = -1;
      for (int i = 0; i < NF; i++) if (m < 0 && tg[i] == g) m = i;
      if (m >= 0) begin
        a = ((cur + int'(ts[m])) % (1 << AW)) & ~7;
        e_found[m] = 1'b1;
        e_pass[m] = (tested[m] ? e_pass[m] : 1'b1) & !stuck.exists(a);
        tested[m] = 1'b1;
      end
      e_hops++;
      if (d[40] || d[39:16] == 24'd0) break;
      if (e_hops == MAXH) begin
        e_eh = 1;
        break;
      end
      cur = (cur + int'(d[39:16])) % (1 << AW);
    end
  endtask

  task automatic apply_table();
    for (int i = 0; i < NF; i++) begin
      tbl_guid[128*i +: 128] = tg[i];
      tbl_scratch[16*i +: 16] = ts[i];
    end
  endtask

  task automatic new_table();
    for (int i = 0; i < NF; i++) begin
      tg[i] = {$urandom, $urandom, $urandom, $urandom};
      ts[i] = 16'((3 + $urandom % 509) * 8);
    end
    apply_table();
  endtask

  task automatic put_node(input int a, input logic [127:0] g, input logic [23:0] off, input bit eol);
    mem[a] = {23'($urandom), eol, off, 16'($urandom)};
    mem[a + 8] = g[63:0];
    mem[a + 16] = g[127:64];
  endtask

  task automatic rand_list(input int n, input bit circ, output int base);
    int pg [8];
    bit used [256];
    int p, sel, np;
    bit last, eol;
    logic [23:0] off;
    mem.delete();
    stuck.delete();
    for (int k = 0; k < n; k++) begin
      do p = $urandom % 256; while (used[p]);
      used[p] = 1;
      pg[k] = p;
    end
    for (int k = 0; k < n; k++) begin
      sel = $urandom % 10;
      last = k == n - 1;
      np = last ? pg[0] : pg[k + 1];
      off = 24'(((np - pg[k]) & 255) << 12);
      eol = 0;
      if (last && !circ) begin
        if ($urandom % 2) off = 24'd0;
        else eol = 1;
      end
      put_node(pg[k] * 4096, sel < NF ? tg[sel] : {$urandom, $urandom, $urandom, $urandom}, off, eol);
      if (sel < NF) begin
        mem[pg[k] * 4096 + int'(ts[sel])] = {$urandom, $urandom};
        if ($urandom % 5 == 0) stuck[pg[k] * 4096 + int'(ts[sel])] = 1;
      end
    end
    base = pg[0] * 4096;
  endtask

  task automatic walk(input string nm, input int base, input int lim);
    int cyc, extra;
    bit dn;
    cyc = 0;
    extra = 0;
    dn = 0;
    model(base);
    @(negedge clk);
    base_addr = AW'(base);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({nm, ".busy"}, busy, 1);
    while (!dn && cyc < lim) begin
      @(negedge clk);
      cyc++;
      if (done) begin
        dn = 1;
        check({nm, ".busy_at_done"}, busy, 0);
      end
    end
    check({nm, ".done"}, dn, 1);
    repeat (4) begin
      @(negedge clk);
      if (done) extra++;
    end
    check({nm, ".done_once"}, extra, 0);
    last_cyc = cyc;
  endtask

  task automatic expect_model(input string nm);
    check({nm, ".found"}, found, e_found);
    check({nm, ".pass"}, pass, e_pass);
    check({nm, ".hops"}, hop_cnt, 64'(e_hops));
    check({nm, ".err_hops"}, err_hops, e_eh);
    check({nm, ".err_timeout"}, err_timeout, 0);
    check({nm, ".latency"}, last_cyc >= 4 * e_hops, 1);
  endtask

  task automatic three_node();
    mem.delete();
    stuck.delete();
    new_table();
    ts[0] = 16'h28;
    ts[1] = 16'h100;
    ts[2] = 16'h18;
    apply_table();
    put_node('h0000, tg[0], 24'h1000, 0);
    put_node('h1000, tg[1], 24'h1000, 0);
    put_node('h2000, tg[2], 24'h0, 1);
    mem['h0028] = 64'hDEAD;
    mem['h1100] = 64'hDEAD;
    mem['h2018] = 64'hDEAD;
  endtask

  initial begin
    int base, cyc;
    bit seen;
    repeat (2) @(negedge clk);
    check("rst.busy", busy, 0);
    check("rst.outs", {done, err_timeout, err_hops, req_valid, found, pass, hop_cnt}, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("idle.outs", {busy, done, req_valid, found, pass, hop_cnt}, 0);

    three_node();
    walk("basic", 0, 500);
    expect_model("basic");
    check("basic.found3", found[2:0], 3'b111);
    check("basic.pass3", pass[2:0], 3'b111);
    check("basic.hops3", hop_cnt, 3);
`ifdef DFH_WALK_RESTORE_EN
    check("basic.scratch_final", rd('h1100), 64'hDEAD);
`else
    check("basic.scratch_final", rd('h1100), PAT ^ 64'd1);
`endif

    three_node();
    stuck['h1100] = 1;
    walk("stuck", 0, 500);
    expect_model("stuck");
    check("stuck.pass3", pass[2:0], 3'b101);

    three_node();
    put_node('h1000, 128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321, 24'h1000, 0);
    walk("unknown", 0, 500);
    expect_model("unknown");
    check("unknown.found3", found[2:0], 3'b101);
    check("unknown.untouched", rd('h1100), 64'hDEAD);

    mem.delete();
    stuck.delete();
    new_table();
    for (int k = 0; k < 8; k++) put_node(k * 'h1000, tg[k], 24'h1000, 0);
    walk("circ", 0, 800);
    expect_model("circ");
    check("circ.err_hops", err_hops, 1);
    check("circ.hops4", hop_cnt, 4);

    for (int it = 0; it < 30; it++) begin
      new_table();
      if (it % 2) begin
        tg[6] = tg[1];
        apply_table();
      end
      rand_list(1 + $urandom % 6, $urandom % 6 == 0, base);
      walk($sformatf("rand%0d", it), base, 1500);
      expect_model($sformatf("rand%0d", it));
    end

    three_node();
    stall_left = 50;
    walk("stall", 0, 800);
    expect_model("stall");
    stall_left = 0;

    three_node();
    drop_addr = 'h0008;
    walk("tmo", 0, TMO + 200);
    drop_addr = -1;
    check("tmo.err_timeout", err_timeout, 1);
    check("tmo.found", found, 0);
    check("tmo.hops", hop_cnt, 0);
    check("tmo.latency", last_cyc >= TMO, 1);
    walk("recover", 0, 500);
    expect_model("recover");

    three_node();
    @(negedge clk);
    base_addr = '0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen = 0;
    cyc = 0;
    while (!seen && cyc < 300) begin
      @(negedge clk);
      cyc++;
      seen = req_valid && req_write;
    end
    check("rstmid.wr_seen", seen, 1);
    #2 rst = 1'b1;
    #1;
    check("rstmid.busy", busy, 0);
    check("rstmid.found", found, 0);
    check("rstmid.req_valid", req_valid, 0);
    @(negedge clk);
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    walk("after_rst", 0, 500);
    expect_model("after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
